seq_pattern_gen: RTL and testbench
==================================

// Module: seq_pattern_gen
// PURPOSE
//  Serial pattern transmitter: on a start pulse, shifts a fixed PAT_W-bit pattern out MSB-first,
//  num_reps times, with an optional idle gap between repetitions.
//  - Stimulus/traffic source for the serial sequence detectors (default pattern 0111).
//  - One bit per accepted valid/ready beat; registered (Moore) outputs.
// PARAMETERS
//  PAT_W    4        pattern length in bits (>=2)
//  PATTERN  4'b0111  pattern to transmit, bit PAT_W-1 sent first
//  CNT_W    8        width of the repetition and gap counters
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      asynchronous, active-low reset
//  start       in   1      one-cycle request; sampled only in IDLE
//  num_reps    in   CNT_W  pattern repetitions to send; latched on accepted start
//  gap_len     in   CNT_W  idle cycles between repetitions; latched on accepted start
//  out_ready   in   1      sink accepts serial_out this cycle
//  serial_out  out  1      current pattern bit
//  out_valid   out  1      serial_out holds a valid pattern bit
//  busy        out  1      high from the cycle after an accepted start through the DONE cycle
//  done        out  1      one-cycle pulse when the sequence completes
// BEHAVIOUR
//  Reset (rst=0, async):
//  - state=IDLE; serial_out=0, out_valid=0, busy=0, done=0.
//  - Counters and latched inputs cleared.
//  - Reset mid-transfer aborts immediately; no done pulse.
//  States IDLE, SHIFT, GAP, DONE:
//  - IDLE: start=1 latches num_reps/gap_len; bit_idx=PAT_W-1. Next: SHIFT, or DONE if num_reps==0.
//  - SHIFT: out_valid=1, serial_out=PATTERN[bit_idx].
//    - Beat = out_valid & out_ready; on a beat, bit_idx decrements.
//    - Beat on bit 0: reps_left decrements. Then DONE if reps_left reaches 0,
//      else GAP if gap_len!=0, else stay in SHIFT with bit_idx=PAT_W-1 (back-to-back, no bubble).
//  - GAP: out_valid=0, serial_out=0 for exactly gap_len cycles, then SHIFT with bit_idx=PAT_W-1.
//  - DONE: done=1 and busy=1 for one cycle, then IDLE; a start in DONE is ignored.
//  Latency: first bit valid in the cycle after start is accepted.
//  Handshake: while out_ready=0, out_valid and serial_out hold stable; out_valid never drops mid-pattern.
//  start while not in IDLE is ignored; num_reps/gap_len changes after latch have no effect.
//  Arithmetic: reps_left and gap counter are CNT_W-bit down-counters; no wrap (stop at 0).
//  Max run: num_reps=2^CNT_W-1 sends all repetitions.
//  Total accepted bits = num_reps*PAT_W.
// STRUCTURE
//  seq_pkg (shared package):
//  - state encoding localparams (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2, DONE=2'd3)
//  - default pattern constant SEQ_PAT_0111
//  - PAT_W default
//  Sub-module seq_down_counter (load/decrement/zero flag, CNT_W wide), instantiated twice:
//  one for repetitions, one for the gap.
//  All other logic (FSM, bit index, output registers) lives in this module.
// TESTING
//  1. Reset: rst=0 mid-SHIFT -> all outputs 0 asynchronously; after release, IDLE and no done pulse.
//  2. start, num_reps=1, gap_len=0, out_ready=1 -> bits 0,1,1,1 on cycles 1-4; done on cycle 5.
//  3. num_reps=3, gap_len=0 -> 12 contiguous valid bits 011101110111; chained detector fires 3 times.
//  4. num_reps=2, gap_len=2 -> 0111, two cycles out_valid=0, 0111, done.
//  5. out_ready toggled 1,0,0,1,... -> each bit held stable while ready=0; sequence still 0111; done after 4th beat.
//  6. num_reps=0 -> done pulse in the cycle after start, out_valid never asserts; start during busy ignored.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants for the serial pattern generator: state encoding and default pattern.
package seq_pkg;

    localparam int unsigned SEQ_PAT_W = 4;
    localparam int unsigned SEQ_CNT_W = 8;

    localparam logic [SEQ_PAT_W-1:0] SEQ_PAT_0111 = 4'b0111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable saturating down-counter with last/zero flags.
module seq_down_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last_c,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // last_c: the next decrement brings the count to zero.
    assign last_c = (cnt_q == CNT_W'(1));
    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends PATTERN MSB-first num_reps times over a
// valid/ready link, with an optional idle gap between repetitions.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int unsigned       PAT_W   = SEQ_PAT_W,
    parameter logic [PAT_W-1:0]  PATTERN = PAT_W'(SEQ_PAT_0111),
    parameter int unsigned       CNT_W   = SEQ_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_reps,
    input  logic [CNT_W-1:0] gap_len,
    input  logic             out_ready,
    output logic             serial_out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    logic [1:0]       state_q, state_nxt;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_nxt;
    logic [CNT_W-1:0] gap_q, gap_nxt;

    logic reps_load, reps_dec, reps_last_c, reps_zero_c;
    logic gap_load, gap_dec, gap_last_c, gap_zero_c;
    logic beat_c;

    logic serial_nxt, valid_nxt, busy_nxt, done_nxt;

    assign beat_c = out_valid & out_ready;

    // Remaining repetitions, loaded from num_reps on an accepted start.
    seq_down_counter #(.CNT_W(CNT_W)) u_reps_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (reps_load),
        .load_val (num_reps),
        .dec      (reps_dec),
        .last_c   (reps_last_c),
        .zero_c   (reps_zero_c)
    );

    // Idle cycles left in the current gap, reloaded from the latched gap length.
    seq_down_counter #(.CNT_W(CNT_W)) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (gap_q),
        .dec      (gap_dec),
        .last_c   (gap_last_c),
        .zero_c   (gap_zero_c)
    );

    // State, bit index and latched gap length.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_nxt;
            bit_idx_q <= bit_idx_nxt;
            gap_q     <= gap_nxt;
        end
    end

    // Next-state, bit index and counter control.
    always_comb begin
        state_nxt   = state_q;
        bit_idx_nxt = bit_idx_q;
        gap_nxt     = gap_q;
        reps_load   = 1'b0;
        reps_dec    = 1'b0;
        gap_load    = 1'b0;
        gap_dec     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    reps_load   = 1'b1;
                    gap_nxt     = gap_len;
                    bit_idx_nxt = IDX_MSB;
                    state_nxt   = (num_reps == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (beat_c) begin
                    if (bit_idx_q == '0) begin
                        reps_dec    = 1'b1;
                        bit_idx_nxt = IDX_MSB;
                        if (reps_last_c || reps_zero_c) begin
                            state_nxt = ST_DONE;
                        end else if (gap_q != '0) begin
                            gap_load  = 1'b1;
                            state_nxt = ST_GAP;
                        end
                    end else begin
                        bit_idx_nxt = bit_idx_q - IDX_W'(1);
                    end
                end
            end
            ST_GAP: begin
                gap_dec = 1'b1;
                if (gap_last_c || gap_zero_c) begin
                    bit_idx_nxt = IDX_MSB;
                    state_nxt   = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output values for the upcoming cycle, decoded from the next state.
    always_comb begin
        serial_nxt = 1'b0;
        valid_nxt  = 1'b0;
        busy_nxt   = (state_nxt != ST_IDLE);
        done_nxt   = (state_nxt == ST_DONE);
        if (state_nxt == ST_SHIFT) begin
            valid_nxt  = 1'b1;
            serial_nxt = PATTERN[bit_idx_nxt];
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            serial_out <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            serial_out <= serial_nxt;
            out_valid  <= valid_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Testbench for seq_pattern_gen: queue-based bit-stream model checked every cycle,
// plus literal expectations on bit streams and done latency.
module tb_seq_pattern_gen;

    localparam int unsigned TB_PAT_W = 4;
    localparam logic [3:0]  TB_PAT   = 4'b0111;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] num_reps;
    logic [7:0] gap_len;
    logic       out_ready;
    logic       serial_out;
    logic       out_valid;
    logic       busy;
    logic       done;

    seq_pattern_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_reps   (num_reps),
        .gap_len    (gap_len),
        .out_ready  (out_ready),
        .serial_out (serial_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Model state: remaining bit stream, expected outputs for the current cycle.
    bit          exp_q[$];
    logic        m_valid = 1'b0;
    logic        m_busy  = 1'b0;
    logic        m_done  = 1'b0;
    int          m_gap   = 0;
    int          m_gap_wait = 0;

    // Observation records used by the literal checks.
    int          cyc_k = 0;
    logic        done_seen = 1'b0;
    int          done_cyc = 0;
    int          beats = 0;
    logic [15:0] log_bits = '0;
    logic [3:0]  det_sh = '0;
    int          det_cnt = 0;

    // Per-cycle compare and model advance.
    always @(negedge clk) begin
        logic nv, nb, nd;
        if (!rst) begin
            exp_q.delete();
            m_valid    = 1'b0;
            m_busy     = 1'b0;
            m_done     = 1'b0;
            m_gap_wait = 0;
        end else begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            if (m_valid && exp_q.size() > 0)
                check("serial_out", 32'(serial_out), 32'(exp_q[0]));
            else
                check("serial_idle", 32'(serial_out), 32'd0);

            if (out_valid && out_ready) begin
                beats++;
                log_bits = {log_bits[14:0], serial_out};
                det_sh   = {det_sh[2:0], serial_out};
                if (det_sh == TB_PAT) det_cnt++;
            end
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc_k;
            end

            nv = m_valid;
            nb = m_busy;
            nd = 1'b0;
            if (m_done) begin
                nb = 1'b0;
                nv = 1'b0;
            end else if (!m_busy) begin
                if (start) begin
                    m_gap = int'(gap_len);
                    for (int r = 0; r < int'(num_reps); r++)
                        for (int i = TB_PAT_W - 1; i >= 0; i--)
                            exp_q.push_back(TB_PAT[i]);
                    nb = 1'b1;
                    if (num_reps == 8'd0) begin
                        nd = 1'b1;
                        nv = 1'b0;
                    end else begin
                        nv = 1'b1;
                    end
                end
            end else if (m_valid) begin
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        nd = 1'b1;
                        nv = 1'b0;
                    end else if ((exp_q.size() % TB_PAT_W) == 0 && m_gap > 0) begin
                        m_gap_wait = m_gap;
                        nv = 1'b0;
                    end
                end
            end else begin
                m_gap_wait--;
                nv = (m_gap_wait == 0);
            end
            m_valid = nv;
            m_busy  = nb;
            m_done  = nd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating. poke_k: cycle to pulse start (0 = none).
    task automatic run_case(input logic [7:0] reps, input logic [7:0] gap, input int mode,
                            input int poke_k, input int max_cyc);
        cyc_k     = 0;
        done_seen = 1'b0;
        done_cyc  = 0;
        beats     = 0;
        log_bits  = '0;
        det_sh    = '0;
        det_cnt   = 0;
        num_reps  = reps;
        gap_len   = gap;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= max_cyc; k++) begin
            cyc_k     = k;
            out_ready = (mode == 0) ? 1'b1 : (((k - 1) % 3) == 0);
            start     = (k == poke_k);
            num_reps  = 8'($urandom);
            gap_len   = 8'($urandom);
            tick();
            if (done_seen) break;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check("timeout", 32'(done_seen), 32'd1);
        tick();
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        num_reps  = '0;
        gap_len   = '0;
        out_ready = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("rst_serial", 32'(serial_out), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Single repetition, no gap.
        run_case(8'd1, 8'd0, 0, 0, 40);
        check("t2_done_cyc", 32'(done_cyc), 32'd5);
        check("t2_beats", 32'(beats), 32'd4);
        check("t2_bits", 32'(log_bits[3:0]), 32'h7);

        // Three back-to-back repetitions; start mid-run ignored.
        run_case(8'd3, 8'd0, 0, 2, 60);
        check("t3_done_cyc", 32'(done_cyc), 32'd13);
        check("t3_bits", 32'(log_bits[11:0]), 32'h777);
        check("t3_detect", 32'(det_cnt), 32'd3);

        // Two repetitions with a two-cycle gap.
        run_case(8'd2, 8'd2, 0, 0, 60);
        check("t4_done_cyc", 32'(done_cyc), 32'd11);
        check("t4_bits", 32'(log_bits[7:0]), 32'h77);

        // Backpressure: ready 1,0,0 repeating.
        run_case(8'd1, 8'd0, 1, 0, 60);
        check("t5_done_cyc", 32'(done_cyc), 32'd11);
        check("t5_beats", 32'(beats), 32'd4);
        check("t5_bits", 32'(log_bits[3:0]), 32'h7);

        // Zero repetitions; start during DONE ignored.
        run_case(8'd0, 8'd5, 0, 1, 20);
        check("t6_done_cyc", 32'(done_cyc), 32'd1);
        check("t6_beats", 32'(beats), 32'd0);

        // Maximum repetition count.
        run_case(8'd255, 8'd0, 0, 0, 1100);
        check("tmax_done_cyc", 32'(done_cyc), 32'd1021);
        check("tmax_beats", 32'(beats), 32'd1020);

        // Asynchronous reset in the middle of a transfer.
        num_reps = 8'd3;
        gap_len  = 8'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #3 rst = 1'b0;
        #1;
        check("arst_serial", 32'(serial_out), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        tick();
        tick();
        done_seen = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check("post_rst_no_done", 32'(done_seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
